comb_sweep_capture: RTL

// - Drives all 2**N_IN input combinations into a combinational block under test,
//   one vector at a time in ascending order, e.g. {A,B,C,D} into comb_Y2.
// - Waits a settle time per vector, samples the block's single-bit result and

---
 rtl/comb_sweep_capture_pkg.sv | 18 +
 rtl/comb_sweep_capture_settle_timer.sv | 28 ++
 rtl/comb_sweep_capture.sv | 129 ++++++++++++
 3 files changed

// File: rtl/comb_sweep_capture_pkg.sv
// rtl/comb_sweep_capture_pkg.sv - shared sweep state encodings and default parameters
package comb_sweep_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } sweep_state_t;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_SETTLE = 2;

    // The timer enters SETTLE already holding the first cycle, hence one less than the hold time.
    function automatic logic [3:0] settle_load(input int settle);
        return 4'(settle - 1);
    endfunction

endpackage

// File: rtl/comb_sweep_capture_settle_timer.sv
// rtl/comb_sweep_capture_settle_timer.sv - 4-bit down-counter timing how long each vector is held
module comb_sweep_capture_settle_timer
    import comb_sweep_capture_pkg::*;
#(
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= settle_load(SETTLE);
        end else if (en && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign expired = en && (cnt == 4'd0);

endmodule

// File: rtl/comb_sweep_capture.sv
// rtl/comb_sweep_capture.sv - exhaustive input sweep of a comb block with truth-table capture
// Optional compare against EXP_TT is built only when SWEEP_CHECK_EN is defined.
module comb_sweep_capture
    import comb_sweep_capture_pkg::*;
#(
    parameter int                N_IN   = DEF_N_IN,
    parameter int                SETTLE = DEF_SETTLE,
    parameter logic [2**N_IN-1:0] EXP_TT = 16'h6996
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 y_in,
    output logic [N_IN-1:0]      abcd,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   truth_table,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt
);

    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0] IDX_LAST = '1;

    sweep_state_t state, state_nxt;

    logic [N_IN-1:0]    idx;
    logic [2**N_IN-1:0] tt_q;
    logic               done_q;
    logic               accept, sample_en, last_vec;
    logic               timer_load, timer_en, expired;

    assign last_vec = (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_SETTLE;
            ST_SETTLE: if (expired) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = last_vec ? ST_IDLE : ST_SETTLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        accept     = (state == ST_IDLE) && start;
        sample_en  = (state == ST_SAMPLE);
        timer_en   = (state == ST_SETTLE);
        timer_load = accept || (sample_en && !last_vec);
    end

    comb_sweep_capture_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .en      (timer_en),
        .expired (expired)
    );

    // idx doubles as the driven vector; it stops at the last vector so abcd never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            tt_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                idx  <= '0;
                tt_q <= '0;
            end else if (sample_en) begin
                tt_q[idx] <= y_in;
                if (last_vec) begin
                    done_q <= 1'b1;
                end else begin
                    idx <= idx + IDX_ONE;
                end
            end
        end
    end

    assign abcd        = idx;
    assign done        = done_q;
    assign truth_table = tt_q;

`ifdef SWEEP_CHECK_EN
    logic [N_IN:0] mm_q;
    logic [N_IN:0] mm_sum;
    logic          pass_q;

    assign mm_sum = mm_q + {{N_IN{1'b0}}, y_in ^ EXP_TT[idx]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_q   <= '0;
            pass_q <= 1'b0;
        end else if (accept) begin
            mm_q   <= '0;
            pass_q <= 1'b0;
        end else if (sample_en) begin
            mm_q <= mm_sum;
            if (last_vec) begin
                pass_q <= (mm_sum == '0);
            end
        end
    end

    assign pass         = pass_q;
    assign mismatch_cnt = mm_q;
`else
    logic unused_exp_tt;

    assign unused_exp_tt = ^EXP_TT;
    assign pass          = 1'b0;
    assign mismatch_cnt  = '0;
`endif

endmodule
